piece_generator: RTL and testbench

Produces the stream of tetrominoes consumed by the game executioner's `new_piece` input. It uses a 7-bag randomizer driven by a 16-bit Galois LFSR and holds drawn pieces in a small FIFO that doubles as the preview queue. The head of the queue is presented continuously as a spawn-ready `tetris_pkg::active_piece_t`. The block sits in the `clk` domain, upstream of the executioner, and advances only on an explicit one-cycle take strobe.

---
 rtl/piece_generator.sv | 193 +++++++++++++++++++
 tb/tb_piece_generator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/piece_generator.sv
// 7-bag tetromino generator: Galois LFSR draws into a small FIFO that doubles as the preview queue.
// Optional `PIECE_GEN_SEED_LOAD_EN adds seed_load/seed_value for runtime reseed + flush.
package tetris_pkg;
    typedef enum logic [1:0] {ROT_0, ROT_90, ROT_180, ROT_270} rotation_t;

    typedef struct packed {
        logic [2:0] piece_type;
        logic [3:0] x;
        logic [4:0] y;
        rotation_t  rotation;
    } active_piece_t;
endpackage

module piece_generator
    import tetris_pkg::*;
#(
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          QUEUE_DEPTH = 2,   // 2..4
    parameter int          SPAWN_X     = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          take_piece,
`ifdef PIECE_GEN_SEED_LOAD_EN
    input  logic          seed_load,
    input  logic [15:0]   seed_value,
`endif
    output active_piece_t new_piece,
    output logic [2:0]    next_type,
    output logic          piece_valid,
    output logic [6:0]    bag_remaining,
    output logic [15:0]   dealt_count,
    output logic          take_err
);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [2:0]  DEPTH    = 3'(QUEUE_DEPTH);
    localparam logic [1:0]  LAST     = 2'(QUEUE_DEPTH - 1);

    typedef enum logic [1:0] {S_FILL, S_DRAW, S_PUSH, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [2:0]  retry_q, retry_d;
    logic [2:0]  draw_q, draw_d;
    logic [6:0]  bag_q, bag_d;
    // Storage is always 4 deep so 2-bit pointers index it cleanly; only QUEUE_DEPTH entries are used.
    logic [2:0]  mem_q [4];
    logic [2:0]  mem_d [4];
    logic [1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] dealt_q, dealt_d;
    logic        err_q, err_d;
    logic [2:0]  head_q, head_d, next_q, next_d;
    logic        valid_q, valid_d;

    logic        full, push, pop, flush;
    logic [15:0] load_val;
    logic [15:0] lfsr_step;
    logic [2:0]  cand;
    logic [7:0]  bag8;
    logic [6:0]  bag_clr;

`ifdef PIECE_GEN_SEED_LOAD_EN
    assign flush    = seed_load;
    assign load_val = (seed_value == 16'h0000) ? 16'h0001 : seed_value;
`else
    assign flush    = 1'b0;
    assign load_val = SEED_EFF;
`endif

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        ptr_inc = (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [2:0] lowest_set(input logic [6:0] m);
        lowest_set = 3'd0;
        for (int i = 6; i >= 0; i--)
            if (m[i]) lowest_set = 3'(i);
    endfunction

    assign full      = (cnt_q == DEPTH);
    assign pop       = take_piece & valid_q & ~flush;
    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign cand      = lfsr_q[2:0];
    // Bit 7 is a permanent zero so candidate 7 rejects without a separate compare.
    assign bag8      = {1'b0, bag_q};
    assign bag_clr   = bag_q & ~(7'b1 << draw_q);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        retry_d = retry_q;
        draw_d  = draw_q;
        bag_d   = bag_q;
        push    = 1'b0;
        case (state_q)
            S_FILL: state_d = full ? S_WAIT : S_DRAW;
            S_DRAW: begin
                lfsr_d = lfsr_step;
                if (bag8[cand]) begin
                    draw_d  = cand;
                    state_d = S_PUSH;
                end else if (retry_q == 3'd7) begin
                    draw_d  = lowest_set(bag_q);
                    state_d = S_PUSH;
                end else begin
                    retry_d = retry_q + 3'd1;
                end
            end
            S_PUSH: begin
                push    = ~full;
                if (push)
                    bag_d = (bag_clr == 7'h00) ? 7'h7F : bag_clr;
                retry_d = 3'd0;
                state_d = S_FILL;
            end
            S_WAIT: if (!full) state_d = S_DRAW;
            default: state_d = S_FILL;
        endcase
        if (flush) begin
            push    = 1'b0;
            lfsr_d  = load_val;
            bag_d   = 7'h7F;
            retry_d = 3'd0;
            state_d = S_FILL;
        end
    end

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = draw_q;
            wr_d        = ptr_inc(wr_q);
        end
        if (pop)
            rd_d = ptr_inc(rd_q);
        cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
        if (flush) begin
            rd_d  = 2'd0;
            wr_d  = 2'd0;
            cnt_d = 3'd0;
        end
        // Outputs are registered from the post-update queue so a pop shows on its own edge.
        valid_d = (cnt_d != 3'd0);
        head_d  = valid_d ? mem_d[rd_d] : 3'd0;
        next_d  = (cnt_d >= 3'd2) ? mem_d[ptr_inc(rd_d)] : 3'd0;
        dealt_d = dealt_q + {15'd0, pop};
        err_d   = err_q | (take_piece & ~valid_q & ~flush);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FILL;
            lfsr_q  <= SEED_EFF;
            retry_q <= 3'd0;
            draw_q  <= 3'd0;
            bag_q   <= 7'h7F;
            mem_q   <= '{default: 3'd0};
            rd_q    <= 2'd0;
            wr_q    <= 2'd0;
            cnt_q   <= 3'd0;
            dealt_q <= 16'd0;
            err_q   <= 1'b0;
            head_q  <= 3'd0;
            next_q  <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            retry_q <= retry_d;
            draw_q  <= draw_d;
            bag_q   <= bag_d;
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            dealt_q <= dealt_d;
            err_q   <= err_d;
            head_q  <= head_d;
            next_q  <= next_d;
            valid_q <= valid_d;
        end
    end

    assign new_piece     = '{piece_type: head_q, x: 4'(SPAWN_X), y: 5'd0, rotation: ROT_0};
    assign next_type     = next_q;
    assign piece_valid   = valid_q;
    assign bag_remaining = bag_q;
    assign dealt_count   = dealt_q;
    assign take_err      = err_q;
endmodule

// File: tb/tb_piece_generator.sv
// Directed bench for piece_generator: default-seed DUT plus a SEED=0 instance.
module tb_piece_generator;
    import tetris_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic take_piece = 1'b0;
    logic z_take = 1'b0;
    active_piece_t new_piece, z_new_piece;
    logic [2:0]  next_type, z_next_type;
    logic        piece_valid, z_piece_valid;
    logic [6:0]  bag_remaining, z_bag_remaining;
    logic [15:0] dealt_count, z_dealt_count;
    logic        take_err, z_take_err;
`ifdef PIECE_GEN_SEED_LOAD_EN
    logic        seed_load = 1'b0;
    logic [15:0] seed_value = 16'h0000;
    logic        z_seed_load = 1'b0;
    logic [15:0] z_seed_value = 16'h0000;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    piece_generator #(.SEED(16'hACE1), .QUEUE_DEPTH(2), .SPAWN_X(4)) dut (
        .clk(clk), .reset(reset), .take_piece(take_piece),
`ifdef PIECE_GEN_SEED_LOAD_EN
        .seed_load(seed_load), .seed_value(seed_value),
`endif
        .new_piece(new_piece), .next_type(next_type), .piece_valid(piece_valid),
        .bag_remaining(bag_remaining), .dealt_count(dealt_count), .take_err(take_err)
    );

    piece_generator #(.SEED(16'h0000), .QUEUE_DEPTH(2), .SPAWN_X(4)) dut_z (
        .clk(clk), .reset(reset), .take_piece(z_take),
`ifdef PIECE_GEN_SEED_LOAD_EN
        .seed_load(z_seed_load), .seed_value(z_seed_value),
`endif
        .new_piece(z_new_piece), .next_type(z_next_type), .piece_valid(z_piece_valid),
        .bag_remaining(z_bag_remaining), .dealt_count(z_dealt_count), .take_err(z_take_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        take_piece = 1'b0;
        z_take = 1'b0;
        #1 reset = 1'b1;
        tick();
        tick();
    endtask

    task automatic release_reset();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        active_piece_t exp_np;
        exp_np = '{piece_type: 3'd0, x: 4'd4, y: 5'd0, rotation: ROT_0};
        apply_reset();
        n_checks++; if (piece_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid got %b exp 0", piece_valid); end
        n_checks++; if (new_piece !== exp_np) begin n_errors++; $display("FAIL rst_new_piece got %h exp %h", new_piece, exp_np); end
        n_checks++; if (next_type !== 3'd0) begin n_errors++; $display("FAIL rst_next got %0d exp 0", next_type); end
        n_checks++; if (bag_remaining !== 7'h7F) begin n_errors++; $display("FAIL rst_bag got %h exp 7f", bag_remaining); end
        n_checks++; if (dealt_count !== 16'd0 || take_err !== 1'b0) begin n_errors++; $display("FAIL rst_cnt_err got %0d/%b exp 0/0", dealt_count, take_err); end
        n_checks++; if (dut.lfsr_q !== 16'hACE1) begin n_errors++; $display("FAIL rst_lfsr got %h exp ace1", dut.lfsr_q); end
        release_reset();
        tick(); tick();
        n_checks++; if (piece_valid !== 1'b0) begin n_errors++; $display("FAIL fill_early_valid got %b exp 0", piece_valid); end
        tick();
        n_checks++; if (piece_valid !== 1'b1 || new_piece.piece_type !== 3'd1) begin n_errors++; $display("FAIL fill_first got v=%b t=%0d exp v=1 t=1", piece_valid, new_piece.piece_type); end
        n_checks++; if (bag_remaining !== 7'h7D) begin n_errors++; $display("FAIL fill_bag1 got %h exp 7d", bag_remaining); end
        tick(); tick(); tick();
        n_checks++; if (bag_remaining !== 7'h7C || dut.cnt_q !== 3'd2) begin n_errors++; $display("FAIL fill_full got bag=%h cnt=%0d exp 7c/2", bag_remaining, dut.cnt_q); end
        n_checks++; if (new_piece.x !== 4'd4 || new_piece.y !== 5'd0 || new_piece.rotation !== ROT_0 || new_piece.piece_type !== 3'd1 || next_type !== 3'd0) begin
            n_errors++; $display("FAIL fill_fields got %h next=%0d exp type1 x4 y0 rot0 next0", new_piece, next_type); end
        n_checks++; if (dut.lfsr_q !== 16'h7138) begin n_errors++; $display("FAIL fill_lfsr got %h exp 7138", dut.lfsr_q); end
        n_checks++; if (z_new_piece.piece_type !== 3'd1 || z_bag_remaining !== 7'h7C) begin n_errors++; $display("FAIL zseed_pieces got t=%0d bag=%h exp 1/7c", z_new_piece.piece_type, z_bag_remaining); end
    endtask

    task automatic test_bag_permutation();
        logic [2:0] types [70];
        logic [6:0] seen;
        int pushes;
        apply_reset();
        release_reset();
        repeat (12) tick();
        for (int k = 1; k <= 70; k++) begin
            types[k-1] = new_piece.piece_type;
            take_piece = 1'b1;
            tick();
            take_piece = 1'b0;
            repeat (11) tick();
            pushes = k + 2;
            n_checks++;
            if (pushes % 7 == 0) begin
                if (bag_remaining !== 7'h7F) begin n_errors++; $display("FAIL bag_reload k=%0d got %h exp 7f", k, bag_remaining); end
            end else if ($countones(bag_remaining) != 7 - (pushes % 7)) begin
                n_errors++; $display("FAIL bag_pop k=%0d got %h exp %0d bits", k, bag_remaining, 7 - (pushes % 7));
            end
        end
        n_checks++; if (types[0] !== 3'd1 || types[1] !== 3'd0 || types[2] !== 3'd4) begin
            n_errors++; $display("FAIL bag_first3 got %0d %0d %0d exp 1 0 4", types[0], types[1], types[2]); end
        for (int g = 0; g < 10; g++) begin
            seen = 7'h00;
            for (int j = 0; j < 7; j++)
                if (types[g*7+j] < 3'd7) seen = seen | (7'b1 << types[g*7+j]);
            n_checks++; if (seen !== 7'h7F) begin n_errors++; $display("FAIL bag_perm group=%0d got %h exp 7f", g, seen); end
        end
        n_checks++; if (dealt_count !== 16'd70) begin n_errors++; $display("FAIL bag_dealt got %0d exp 70", dealt_count); end
    endtask

    task automatic test_empty_take();
        apply_reset();
        release_reset();
        take_piece = 1'b1;
        tick();
        take_piece = 1'b0;
        n_checks++; if (take_err !== 1'b1 || dealt_count !== 16'd0) begin n_errors++; $display("FAIL empty_take got err=%b dealt=%0d exp 1/0", take_err, dealt_count); end
        tick(); tick();
        n_checks++; if (piece_valid !== 1'b1 || new_piece.piece_type !== 3'd1) begin n_errors++; $display("FAIL empty_first got v=%b t=%0d exp 1/1", piece_valid, new_piece.piece_type); end
        repeat (10) tick();
        n_checks++; if (take_err !== 1'b1 || dealt_count !== 16'd0 || bag_remaining !== 7'h7C) begin
            n_errors++; $display("FAIL empty_sticky got err=%b dealt=%0d bag=%h exp 1/0/7c", take_err, dealt_count, bag_remaining); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] pre_next;
        int t;
        apply_reset();
        release_reset();
        repeat (12) tick();
        pre_next = next_type;
        n_checks++; if (pre_next !== 3'd0 || new_piece.piece_type !== 3'd1) begin n_errors++; $display("FAIL b2b_pre got head=%0d next=%0d exp 1/0", new_piece.piece_type, pre_next); end
        take_piece = 1'b1;
        tick();
        n_checks++; if (new_piece.piece_type !== pre_next || dealt_count !== 16'd1 || piece_valid !== 1'b1) begin
            n_errors++; $display("FAIL b2b_pop1 got t=%0d dealt=%0d v=%b exp %0d/1/1", new_piece.piece_type, dealt_count, piece_valid, pre_next); end
        tick();
        n_checks++; if (dealt_count !== 16'd2 || piece_valid !== 1'b0 || take_err !== 1'b0) begin
            n_errors++; $display("FAIL b2b_pop2 got dealt=%0d v=%b err=%b exp 2/0/0", dealt_count, piece_valid, take_err); end
        tick();
        take_piece = 1'b0;
        n_checks++; if (dealt_count !== 16'd2 || take_err !== 1'b1) begin n_errors++; $display("FAIL b2b_third got dealt=%0d err=%b exp 2/1", dealt_count, take_err); end
        t = 0;
        while (piece_valid !== 1'b1 && t < 20) begin tick(); t++; end
        n_checks++; if (piece_valid !== 1'b1 || new_piece.piece_type !== 3'd4) begin
            n_errors++; $display("FAIL b2b_refill got v=%b t=%0d exp 1/4", piece_valid, new_piece.piece_type); end
    endtask

    task automatic test_zero_seed();
        logic zero_seen;
        apply_reset();
        n_checks++; if (dut_z.lfsr_q !== 16'h0001) begin n_errors++; $display("FAIL zseed_init got %h exp 0001", dut_z.lfsr_q); end
        release_reset();
        zero_seen = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            z_take = (c % 12 == 0);
            tick();
            z_take = 1'b0;
            if (dut_z.lfsr_q == 16'h0000) zero_seen = 1'b1;
        end
        n_checks++; if (zero_seen !== 1'b0) begin n_errors++; $display("FAIL zseed_lfsr_zero got 1 exp 0"); end
        n_checks++; if (z_dealt_count !== 16'd25 || z_take_err !== 1'b0) begin n_errors++; $display("FAIL zseed_dealt got %0d err=%b exp 25/0", z_dealt_count, z_take_err); end
    endtask

`ifdef PIECE_GEN_SEED_LOAD_EN
    task automatic collect14(output logic [2:0] seq [14], output bit timeout);
        int t;
        timeout = 1'b0;
        for (int i = 0; i < 14; i++) begin
            t = 0;
            while (piece_valid !== 1'b1 && t < 20) begin tick(); t++; end
            if (piece_valid !== 1'b1) timeout = 1'b1;
            seq[i] = new_piece.piece_type;
            take_piece = 1'b1;
            tick();
            take_piece = 1'b0;
        end
    endtask

    task automatic test_seed_load();
        logic [2:0] s1 [14];
        logic [2:0] s2 [14];
        bit to1, to2;
        int diffs;
        apply_reset();
        release_reset();
        repeat (12) tick();
        seed_load = 1'b1; seed_value = 16'h1234;
        tick();
        seed_load = 1'b0;
        n_checks++; if (piece_valid !== 1'b0 || bag_remaining !== 7'h7F) begin n_errors++; $display("FAIL sl_flush1 got v=%b bag=%h exp 0/7f", piece_valid, bag_remaining); end
        collect14(s1, to1);
        n_checks++; if (to1 || s1[0] !== 3'd4) begin n_errors++; $display("FAIL sl_first got t=%0d timeout=%0d exp 4/0", s1[0], to1); end
        repeat (12) tick();
        seed_load = 1'b1; seed_value = 16'h1234;
        tick();
        seed_load = 1'b0;
        n_checks++; if (piece_valid !== 1'b0 || dealt_count !== 16'd14) begin n_errors++; $display("FAIL sl_flush2 got v=%b dealt=%0d exp 0/14", piece_valid, dealt_count); end
        collect14(s2, to2);
        diffs = 0;
        for (int i = 0; i < 14; i++) if (s1[i] !== s2[i]) diffs++;
        n_checks++; if (to2 || diffs != 0) begin n_errors++; $display("FAIL sl_repeat got %0d diffs timeout=%0d exp 0", diffs, to2); end
    endtask
`endif

    initial begin
        test_reset();
        test_bag_permutation();
        test_empty_take();
        test_back_to_back();
        test_zero_seed();
`ifdef PIECE_GEN_SEED_LOAD_EN
        test_seed_load();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
